mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 ex_mem_valid  in  1  EX holds a valid instruction for MEM.
REQ-004 ex_mem_bus  in  `EX_MEM_BUS_WDTH  {csr_we, csr_waddr[13:0], csr_wmask[31:0], csr_wdata[31:0], inst_ertn, exc_type[5:0], ld_type[4:0], gr_we, pc[31:0], inst[31:0], alu_result[31:0], dest[4:0]}.
REQ-005 data_sram_rdata  in  32  load data; valid the cycle the instruction occupies MEM.
REQ-006 wb_allowin  in  1  WB can accept this cycle.
REQ-007 wb_flush  in  1  WB exception or ertn (wb_exc | ertn_flush).
REQ-008 mem_allowin  out  1  MEM can accept from EX.
REQ-009 mem_wb_valid  out  1  MEM presents a valid instruction to WB.
REQ-010 mem_wb_bus  out  `MEM_WB_BUS_WDTH  {csr_we, csr_waddr, csr_wmask, csr_wdata, inst_ertn, exc_type[5:0], gr_we, pc, inst, final_result, dest}.
REQ-011 mem_id_bus  out  39  forward/block info to ID: {mem_valid & gr_we, mem_is_load, dest[4:0], final_result[31:0]}.
REQ-012 mem_csr_blk_bus  out  16  {mem_valid & csr_we, mem_valid & inst_ertn, csr_waddr[13:0]} for ID CSR hazard.

Function
REQ-013 Pipeline register mem_valid: mem_ready_go = 1; mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
REQ-014 When mem_allowin=1, mem_valid <= ex_mem_valid & ~wb_flush & ~flush_hold; bus register loads only when ex_mem_valid & mem_allowin.
REQ-015 mem_wb_valid = mem_valid & mem_ready_go & ~flush_hold & ~wb_flush.
REQ-016 flush_hold: set on wb_flush; cleared on first cycle ex_mem_valid & mem_allowin & ~wb_flush (first post-redirect instruction); wb_flush wins over clear when simultaneous.
REQ-017 ld_type one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; byte lane = alu_result[1:0], half lane = alu_result[1].
REQ-018 ld_b/ld_bu: selected byte sign-/zero-extended to 32; ld_h/ld_hu: selected half sign-/zero-extended; ld_w: rdata unchanged.
REQ-019 final_result = load value if |ld_type and exc_type==0, else alu_result (carries bad address for ALE to WB badvaddr).
REQ-020 exc_type passes unchanged; no new exceptions raised in MEM.
REQ-021 An instruction with non-zero exc_type forces gr_we=0 and csr_we=0 in mem_wb_bus.
REQ-022 mem_id_bus and mem_csr_blk_bus valid bits are 0 when mem_valid=0 or flush_hold=1.
REQ-023 Stall: wb_allowin=0 holds bus register and mem_valid; final_result recomputed from held rdata, which EX guarantees stable.

Reset
REQ-024 On resetn=0 at clk edge: mem_valid=0, flush_hold=0; mem_wb_valid=0, all mem_id_bus/mem_csr_blk_bus valid bits 0 next cycle; data register contents don't-care.
REQ-025 Reset mid-stall discards the held instruction; no output valid until a new ex_mem_valid handshake.

Structure
REQ-026 Bus widths, ld_type bit indices, TYPE_* exception indices in shared header mycpu.h.
REQ-027 One sub-module load_align (rdata, addr[1:0], ld_type -> 32-bit value), purely combinational.

Verification
REQ-028 ld_b addr=0x...3, rdata=0x80FF_1234 -> final_result 0xFFFF_FF80; ld_bu same -> 0x0000_0080.
REQ-029 ld_h addr=0x...2, rdata=0x8001_0000 -> 0xFFFF_8001; ld_hu -> 0x0000_8001; ld_w -> 0x8001_0000.
REQ-030 wb_allowin=0 for 3 cycles with valid instruction -> mem_allowin=0, bus stable, mem_wb_valid held 1; released -> one transfer only.
REQ-031 wb_flush pulse while MEM holds instruction and EX offers next -> both dropped, mem_wb_valid=0 until next ex_mem_valid after flush.
REQ-032 ALE load (exc_type[ALE]=1, alu_result=0x1C00_0002) -> final_result 0x1C00_0002, gr_we=0.
REQ-033 resetn=0 during stall -> mem_wb_valid=0 next cycle, mem_allowin=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, field indices and bus payload types for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned EX_MEM_BUS_WDTH  = 193;
  localparam int unsigned MEM_WB_BUS_WDTH  = 188;
  localparam int unsigned MEM_ID_BUS_WDTH  = 39;
  localparam int unsigned MEM_CSR_BLK_WDTH = 16;
  localparam int unsigned LD_TYPE_WDTH     = 5;
  localparam int unsigned EXC_TYPE_WDTH    = 6;

  // ld_type one-hot bit positions: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int unsigned LD_W  = 0;
  localparam int unsigned LD_HU = 1;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_BU = 3;
  localparam int unsigned LD_B  = 4;

  // exc_type bit carrying an address-alignment fault
  localparam int unsigned TYPE_ALE = 4;

  typedef struct packed {
    logic                     csr_we;
    logic [13:0]              csr_waddr;
    logic [31:0]              csr_wmask;
    logic [31:0]              csr_wdata;
    logic                     inst_ertn;
    logic [EXC_TYPE_WDTH-1:0] exc_type;
    logic [LD_TYPE_WDTH-1:0]  ld_type;
    logic                     gr_we;
    logic [31:0]              pc;
    logic [31:0]              inst;
    logic [31:0]              alu_result;
    logic [4:0]               dest;
  } ex_mem_bus_t;

  typedef struct packed {
    logic                     csr_we;
    logic [13:0]              csr_waddr;
    logic [31:0]              csr_wmask;
    logic [31:0]              csr_wdata;
    logic                     inst_ertn;
    logic [EXC_TYPE_WDTH-1:0] exc_type;
    logic                     gr_we;
    logic [31:0]              pc;
    logic [31:0]              inst;
    logic [31:0]              final_result;
    logic [4:0]               dest;
  } mem_wb_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake and bus signals; slave is the MEM stage, master its surroundings.
interface mem_stage_if;

  logic                                        ex_mem_valid;
  logic [mem_stage_pkg::EX_MEM_BUS_WDTH-1:0]   ex_mem_bus;
  logic [31:0]                                 data_sram_rdata;
  logic                                        wb_allowin;
  logic                                        wb_flush;
  logic                                        mem_allowin;
  logic                                        mem_wb_valid;
  logic [mem_stage_pkg::MEM_WB_BUS_WDTH-1:0]   mem_wb_bus;
  logic [mem_stage_pkg::MEM_ID_BUS_WDTH-1:0]   mem_id_bus;
  logic [mem_stage_pkg::MEM_CSR_BLK_WDTH-1:0]  mem_csr_blk_bus;

  modport master (
    output ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin, wb_flush,
    input  mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_csr_blk_bus
  );

  modport slave (
    input  ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin, wb_flush,
    output mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_csr_blk_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half and sign- or zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]             rdata,
  input  logic [1:0]              addr,
  input  logic [LD_TYPE_WDTH-1:0] ld_type,
  output logic [31:0]             value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension; ld_w and non-loads pass rdata through
  always_comb begin
    byte_sel = 8'(rdata >> {addr, 3'b000});
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    value    = rdata;
    if (ld_type[LD_B]) begin
      value = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_type[LD_BU]) begin
      value = {24'h0, byte_sel};
    end else if (ld_type[LD_H]) begin
      value = {{16{half_sel[15]}}, half_sel};
    end else if (ld_type[LD_HU]) begin
      value = {16'h0, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, aligns load data, forwards to WB/ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);

  ex_mem_bus_t ex_in;
  ex_mem_bus_t mem_r;
  mem_wb_bus_t wb_out;
  logic        mem_valid;
  logic        flush_hold;
  logic        mem_ready_go;
  logic        allowin;
  logic        live;
  logic        has_exc;
  logic        is_load;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign ex_in        = bus.ex_mem_bus;
  assign mem_ready_go = 1'b1;
  assign allowin      = ~mem_valid | (mem_ready_go & bus.wb_allowin);

  // Valid bit and post-flush suppression; a new flush beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid  <= 1'b0;
      flush_hold <= 1'b0;
    end else begin
      if (allowin) begin
        mem_valid <= bus.ex_mem_valid & ~bus.wb_flush & ~flush_hold;
      end
      if (bus.wb_flush) begin
        flush_hold <= 1'b1;
      end else if (bus.ex_mem_valid && allowin) begin
        flush_hold <= 1'b0;
      end
    end
  end

  // Payload register: loads only on an EX->MEM handshake, held across stalls
  always_ff @(posedge clk) begin
    if (bus.ex_mem_valid && allowin) begin
      mem_r <= ex_in;
    end
  end

  mem_stage_load_align u_load_align (
    .rdata   (bus.data_sram_rdata),
    .addr    (mem_r.alu_result[1:0]),
    .ld_type (mem_r.ld_type),
    .value   (load_val)
  );

  // Result select and WB payload; a faulting instruction keeps its address and loses its writes
  always_comb begin
    has_exc      = |mem_r.exc_type;
    is_load      = |mem_r.ld_type;
    final_result = (is_load && !has_exc) ? load_val : mem_r.alu_result;
    live         = mem_valid & ~flush_hold;

    wb_out              = '0;
    wb_out.csr_we       = mem_r.csr_we & ~has_exc;
    wb_out.csr_waddr    = mem_r.csr_waddr;
    wb_out.csr_wmask    = mem_r.csr_wmask;
    wb_out.csr_wdata    = mem_r.csr_wdata;
    wb_out.inst_ertn    = mem_r.inst_ertn;
    wb_out.exc_type     = mem_r.exc_type;
    wb_out.gr_we        = mem_r.gr_we & ~has_exc;
    wb_out.pc           = mem_r.pc;
    wb_out.inst         = mem_r.inst;
    wb_out.final_result = final_result;
    wb_out.dest         = mem_r.dest;
  end

  assign bus.mem_allowin     = allowin;
  assign bus.mem_wb_valid    = mem_valid & mem_ready_go & ~flush_hold & ~bus.wb_flush;
  assign bus.mem_wb_bus      = wb_out;
  assign bus.mem_id_bus      = {live & mem_r.gr_we, live & is_load, mem_r.dest, final_result};
  assign bus.mem_csr_blk_bus = {live & mem_r.csr_we, live & mem_r.inst_ertn, mem_r.csr_waddr};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: issue pushes expected WB payloads, a monitor pops on each transfer.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [4:0] LDB  = 5'b10000;
  localparam logic [4:0] LDBU = 5'b01000;
  localparam logic [4:0] LDH  = 5'b00100;
  localparam logic [4:0] LDHU = 5'b00010;
  localparam logic [4:0] LDW  = 5'b00001;
  localparam logic [4:0] ALU  = 5'b00000;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  mem_wb_bus_t sb[$];
  mem_wb_bus_t mon_exp;
  mem_wb_bus_t hold_exp;
  ex_mem_bus_t vb;

  always #5 clk = ~clk;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  function automatic ex_mem_bus_t mk(input logic [4:0] ld, input logic [31:0] alu,
                                     input logic [5:0] exc, input logic grwe,
                                     input logic csrwe, input logic [4:0] dest);
    ex_mem_bus_t b;
    b.csr_we     = csrwe;
    b.csr_waddr  = 14'h0044;
    b.csr_wmask  = 32'hFFFF_0000;
    b.csr_wdata  = 32'hA5A5_0000 | {27'h0, dest};
    b.inst_ertn  = 1'b0;
    b.exc_type   = exc;
    b.ld_type    = ld;
    b.gr_we      = grwe;
    b.pc         = 32'h1C00_0000 + {25'h0, dest, 2'b00};
    b.inst       = 32'h2880_0000 | {27'h0, dest};
    b.alu_result = alu;
    b.dest       = dest;
    return b;
  endfunction

  function automatic mem_wb_bus_t wb_exp(input ex_mem_bus_t b, input logic [31:0] fr,
                                         input logic grwe, input logic csrwe);
    mem_wb_bus_t w;
    w.csr_we       = csrwe;
    w.csr_waddr    = b.csr_waddr;
    w.csr_wmask    = b.csr_wmask;
    w.csr_wdata    = b.csr_wdata;
    w.inst_ertn    = b.inst_ertn;
    w.exc_type     = b.exc_type;
    w.gr_we        = grwe;
    w.pc           = b.pc;
    w.inst         = b.inst;
    w.final_result = fr;
    w.dest         = b.dest;
    return w;
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Offer b from posedge+1, wait for the handshake, then drive its load data for the MEM cycle
  task automatic issue(input ex_mem_bus_t b, input logic [31:0] rd, input bit keep,
                       input logic [31:0] fr, input logic grwe, input logic csrwe);
    int n;
    ifc.ex_mem_valid = 1'b1;
    ifc.ex_mem_bus   = b;
    if (keep) sb.push_back(wb_exp(b, fr, grwe, csrwe));
    n = 0;
    @(negedge clk);
    while (ifc.mem_allowin !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (ifc.mem_allowin !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: mem_allowin %b want 1", ifc.mem_allowin);
    end
    @(posedge clk);
    #1;
    ifc.ex_mem_valid    = 1'b0;
    ifc.data_sram_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted MEM->WB transfer must match the oldest expected payload
  always @(negedge clk) begin
    if (resetn === 1'b1 && ifc.mem_wb_valid === 1'b1 && ifc.wb_allowin === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: got pc %h result %h, want no transfer",
                 ifc.mem_wb_bus[100:69], ifc.mem_wb_bus[36:5]);
      end else begin
        mon_exp = sb.pop_front();
        chk("wb_bus", 192'(ifc.mem_wb_bus), 192'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    resetn              = 1'b0;
    ifc.ex_mem_valid    = 1'b0;
    ifc.ex_mem_bus      = '0;
    ifc.data_sram_rdata = 32'h0;
    ifc.wb_allowin      = 1'b1;
    ifc.wb_flush        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
    chk("rst_allowin", 192'(ifc.mem_allowin), 192'(1'b1));
    chk("rst_id_valid", 192'(ifc.mem_id_bus[38:37]), 192'(2'b00));
    chk("rst_csr_valid", 192'(ifc.mem_csr_blk_bus[15:14]), 192'(2'b00));
    step();
    resetn = 1'b1;
    step();

    // Back-to-back loads, ALU op, CSR write and an ALE fault
    issue(mk(LDB,  32'h1C00_0103, 6'h0, 1'b1, 1'b0, 5'd1), 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
    issue(mk(LDBU, 32'h1C00_0103, 6'h0, 1'b1, 1'b0, 5'd2), 32'h80FF_1234, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
    issue(mk(LDH,  32'h1C00_0202, 6'h0, 1'b1, 1'b0, 5'd3), 32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0);
    issue(mk(LDHU, 32'h1C00_0202, 6'h0, 1'b1, 1'b0, 5'd4), 32'h8001_0000, 1'b1, 32'h0000_8001, 1'b1, 1'b0);
    issue(mk(LDW,  32'h1C00_0200, 6'h0, 1'b1, 1'b0, 5'd5), 32'h8001_0000, 1'b1, 32'h8001_0000, 1'b1, 1'b0);
    issue(mk(LDB,  32'h1C00_0101, 6'h0, 1'b1, 1'b0, 5'd6), 32'h80FF_1234, 1'b1, 32'h0000_0012, 1'b1, 1'b0);
    issue(mk(LDB,  32'h1C00_0102, 6'h0, 1'b1, 1'b0, 5'd7), 32'h80FF_1234, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(mk(LDBU, 32'h1C00_0100, 6'h0, 1'b1, 1'b0, 5'd8), 32'h80FF_1234, 1'b1, 32'h0000_0034, 1'b1, 1'b0);
    issue(mk(LDH,  32'h1C00_0300, 6'h0, 1'b1, 1'b0, 5'd9), 32'h1234_F00D, 1'b1, 32'hFFFF_F00D, 1'b1, 1'b0);
    issue(mk(LDHU, 32'h1C00_0300, 6'h0, 1'b1, 1'b0, 5'd10), 32'h1234_F00D, 1'b1, 32'h0000_F00D, 1'b1, 1'b0);
    issue(mk(ALU,  32'hDEAD_BEEF, 6'h0, 1'b1, 1'b0, 5'd11), 32'h5555_5555, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    issue(mk(ALU,  32'h0000_0042, 6'h0, 1'b0, 1'b1, 5'd12), 32'h5555_5555, 1'b1, 32'h0000_0042, 1'b0, 1'b1);
    issue(mk(LDW,  32'h1C00_0002, 6'(1 << TYPE_ALE), 1'b1, 1'b1, 5'd13), 32'h1111_2222, 1'b1,
          32'h1C00_0002, 1'b0, 1'b0);
    step();
    step();

    // Stall: WB blocks for 3 cycles while EX already offers the next instruction
    ifc.wb_allowin = 1'b0;
    vb = mk(LDH, 32'h1C00_2002, 6'h0, 1'b1, 1'b1, 5'd7);
    hold_exp = wb_exp(vb, 32'hFFFF_8001, 1'b1, 1'b1);
    issue(vb, 32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b1, 1'b1);
    vb = mk(ALU, 32'h0000_1234, 6'h0, 1'b1, 1'b0, 5'd9);
    ifc.ex_mem_valid = 1'b1;
    ifc.ex_mem_bus   = vb;
    sb.push_back(wb_exp(vb, 32'h0000_1234, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_allowin", 192'(ifc.mem_allowin), 192'(1'b0));
      chk("stall_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b1));
      chk("stall_wb_bus", 192'(ifc.mem_wb_bus), 192'(hold_exp));
      chk("stall_id_bus", 192'(ifc.mem_id_bus), 192'({1'b1, 1'b1, 5'd7, 32'hFFFF_8001}));
      chk("stall_csr_blk", 192'(ifc.mem_csr_blk_bus), 192'({1'b1, 1'b0, 14'h0044}));
      step();
    end
    ifc.wb_allowin = 1'b1;
    step();
    ifc.ex_mem_valid = 1'b0;
    step();
    @(negedge clk);
    chk("post_stall_idle", 192'(ifc.mem_wb_valid), 192'(1'b0));
    step();

    // Flush: MEM holds A, EX offers B in the flush cycle; C is the first post-flush handshake
    ifc.wb_allowin = 1'b0;
    issue(mk(LDW, 32'h1C00_0400, 6'h0, 1'b1, 1'b1, 5'd20), 32'hCAFE_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    ifc.ex_mem_valid = 1'b1;
    ifc.ex_mem_bus   = mk(ALU, 32'h0000_0021, 6'h0, 1'b1, 1'b1, 5'd21);
    ifc.wb_flush     = 1'b1;
    ifc.wb_allowin   = 1'b1;
    @(negedge clk);
    chk("flush_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
    chk("flush_allowin", 192'(ifc.mem_allowin), 192'(1'b1));
    step();
    ifc.wb_flush     = 1'b0;
    ifc.ex_mem_valid = 1'b0;
    @(negedge clk);
    chk("flushed_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
    chk("flushed_id_valid", 192'(ifc.mem_id_bus[38:37]), 192'(2'b00));
    chk("flushed_csr_valid", 192'(ifc.mem_csr_blk_bus[15:14]), 192'(2'b00));
    step();
    issue(mk(ALU, 32'h0000_0022, 6'h0, 1'b1, 1'b0, 5'd22), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_drop_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
    step();
    issue(mk(LDBU, 32'h1C00_0503, 6'h0, 1'b1, 1'b0, 5'd23), 32'h80FF_1234, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
    step();

    // Reset while stalled discards the held instruction
    ifc.wb_allowin = 1'b0;
    issue(mk(LDW, 32'h1C00_0600, 6'h0, 1'b1, 1'b1, 5'd24), 32'h7777_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    resetn = 1'b0;
    step();
    @(negedge clk);
    chk("rst_stall_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
    chk("rst_stall_allowin", 192'(ifc.mem_allowin), 192'(1'b1));
    chk("rst_stall_id_valid", 192'(ifc.mem_id_bus[38:37]), 192'(2'b00));
    chk("rst_stall_csr_valid", 192'(ifc.mem_csr_blk_bus[15:14]), 192'(2'b00));
    step();
    resetn         = 1'b1;
    ifc.wb_allowin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_after_wb_valid", 192'(ifc.mem_wb_valid), 192'(1'b0));
      step();
    end
    issue(mk(LDHU, 32'h1C00_0702, 6'h0, 1'b1, 1'b0, 5'd25), 32'hBEEF_0000, 1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    repeat (3) step();

    chk("scoreboard_drained", 192'(sb.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
